// File: rtl/rv32i_trace_buffer.sv
// Retire-trace capture buffer: filters retire events, optionally waits for a
// PC trigger and a post-trigger count, and stores accepted events in an output
// slot followed by DEPTH-entry circular storage.
module rv32i_trace_buffer #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 16,
  parameter  int CNT_W = 16,
  localparam int LW    = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             cmd_arm,
  input  logic             cmd_stop,
  input  logic [2:0]       cfg_filter,
  input  logic             cfg_wrap,
  input  logic             cfg_trig_en,
  input  logic [XLEN-1:0]  cfg_trig_pc,
  input  logic [CNT_W-1:0] cfg_post,
  input  logic             ev_valid,
  input  logic [XLEN-1:0]  ev_pc,
  input  logic [XLEN-1:0]  ev_instr,
  input  logic [XLEN-1:0]  ev_wb_data,
  input  logic [XLEN-1:0]  ev_mem_addr,
  input  logic [4:0]       ev_rd_addr,
  input  logic             ev_reg_write,
  input  logic             ev_mem_read,
  input  logic             ev_mem_write,
  input  logic             ev_branch_taken,
  input  logic             ev_jal,
  input  logic             ev_jalr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_wb_data,
  output logic [XLEN-1:0]  out_mem_addr,
  output logic [4:0]       out_rd_addr,
  output logic [5:0]       out_flags,
  output logic [1:0]       state,
  output logic [LW-1:0]    level,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] wb;
    logic [XLEN-1:0] addr;
    logic [4:0]      rd;
    logic [5:0]      flags;
  } ent_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPT = 2'd2, S_DONE = 2'd3} state_t;

  state_t           r_state, w_nstate;
  logic [2:0]       r_filter;
  logic             r_wrap;
  logic [XLEN-1:0]  r_trig_pc;
  logic [CNT_W-1:0] r_post, r_post_cnt, w_post_nxt, r_drop;
  ent_t             w_ev, r_out;
  ent_t             r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr;
  logic [AW:0]      r_cnt;
  logic             r_ov;
  logic             w_qual, w_match, w_push, w_pop, w_empty, w_full;
  logic             w_direct, w_take, w_lost, w_mem_we, w_cnt_inc;

  assign w_ev = '{pc: ev_pc, instr: ev_instr, wb: ev_wb_data, addr: ev_mem_addr, rd: ev_rd_addr,
                  flags: {ev_jalr, ev_jal, ev_branch_taken, ev_mem_write, ev_mem_read, ev_reg_write}};

  assign w_qual  = ev_valid & ((r_filter == 3'd0)
                 | (r_filter[0] & ev_reg_write)
                 | (r_filter[1] & (ev_mem_read | ev_mem_write))
                 | (r_filter[2] & (ev_branch_taken | ev_jal | ev_jalr)));
  assign w_match = ev_valid & (ev_pc == r_trig_pc);

  // Storage bookkeeping. The output slot refills whenever it is empty or being
  // popped: from the storage head if any, else straight from the new event.
  assign w_pop     = r_ov & out_ready;
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_direct  = (w_pop | ~r_ov) & w_empty;
  assign w_take    = (w_pop | ~r_ov) & ~w_empty;
  assign w_lost    = w_push & w_full & ~w_pop;
  assign w_mem_we  = w_push & ~w_direct & ~(w_lost & ~r_wrap);
  assign w_cnt_inc = w_mem_we & ~w_lost;

  // Next state, push qualification and post-trigger count
  always_comb begin
    w_nstate   = r_state;
    w_push     = 1'b0;
    w_post_nxt = r_post_cnt;
    if (cmd_arm) begin
      w_nstate = cfg_trig_en ? S_ARMED : S_CAPT;
    end else begin
      case (r_state)
        S_ARMED: begin
          // Trigger matches on PC alone; the filter only decides whether it is stored
          w_push = w_match & w_qual;
          if (w_match) w_post_nxt = CNT_W'(1);
          if (cmd_stop) w_nstate = S_DONE;
          else if (w_match) w_nstate = (r_post == CNT_W'(1)) ? S_DONE : S_CAPT;
        end
        S_CAPT: begin
          w_push = w_qual;
          if (w_qual) w_post_nxt = r_post_cnt + CNT_W'(1);
          if (cmd_stop || (w_qual && r_post != '0 && w_post_nxt == r_post)) w_nstate = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // State and post-trigger counter registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= S_IDLE;
      r_post_cnt <= '0;
    end else begin
      r_state    <= w_nstate;
      r_post_cnt <= cmd_arm ? '0 : w_post_nxt;
    end
  end

  // Config latch, output slot, pointers, occupancy and drop counter
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_filter  <= '0;
      r_wrap    <= 1'b0;
      r_trig_pc <= '0;
      r_post    <= '0;
      r_out     <= '0;
      r_ov      <= 1'b0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_cnt     <= '0;
      r_drop    <= '0;
    end else if (cmd_arm) begin
      r_filter  <= cfg_filter;
      r_wrap    <= cfg_wrap;
      r_trig_pc <= cfg_trig_pc;
      r_post    <= cfg_post;
      r_out     <= '0;
      r_ov      <= 1'b0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_cnt     <= '0;
      r_drop    <= '0;
    end else begin
      if (w_take) begin
        r_out <= r_mem[r_rd];
        r_ov  <= 1'b1;
      end else if (w_direct) begin
        if (w_push) r_out <= w_ev;
        r_ov <= w_push;
      end
      // Overwrite-oldest retires the storage head to make room
      if (w_take || (w_mem_we && w_lost)) r_rd <= r_rd + AW'(1);
      if (w_mem_we) r_wr <= r_wr + AW'(1);
      if (w_cnt_inc && !w_take) r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_cnt_inc && w_take) r_cnt <= r_cnt - (AW+1)'(1);
      if (w_lost && r_drop != '1) r_drop <= r_drop + CNT_W'(1);
    end
  end

  // Storage array write port (no reset needed; validity tracked by pointers)
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr] <= w_ev;
  end

  assign out_valid    = r_ov;
  assign out_pc       = r_out.pc;
  assign out_instr    = r_out.instr;
  assign out_wb_data  = r_out.wb;
  assign out_mem_addr = r_out.addr;
  assign out_rd_addr  = r_out.rd;
  assign out_flags    = r_out.flags;
  assign state        = r_state;
  assign level        = LW'(r_cnt) + LW'(r_ov);
  assign drop_cnt     = r_drop;
endmodule
